// File: rtl/id_ex_stage_pkg.sv
// Shared defaults, ALUOp encodings and control-bundle types for the ID/EX stage.
package id_ex_stage_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int REG_AW_DEF  = 5;
    localparam int ALUOP_W_DEF = 3;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_FUNCT = 3'd2,
        ALU_AND   = 3'd3,
        ALU_OR    = 3'd4,
        ALU_SLT   = 3'd5,
        ALU_LUI   = 3'd6,
        ALU_XOR   = 3'd7
    } aluOp_e;

    typedef struct packed {
        logic regWrite;
        logic memRead;
        logic memWrite;
        logic memtoReg;
        logic aluSrc;
        logic regDst;
    } ctrl_t;

    // A bubble carries no side effects: every control bit cleared.
    localparam ctrl_t BUBBLE_CTRL = 6'b000000;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard equation: the load in EX writes a register the ID instruction reads.
module load_use_detect
    import id_ex_stage_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              EX_MemRead,
    input  logic [REG_AW-1:0] EX_WR_out,
    input  logic [REG_AW-1:0] ID_Rs,
    input  logic [REG_AW-1:0] ID_Rt,
    input  logic              ID_UseRs,
    input  logic              ID_UseRt,
    output logic              hz
);

    logic rsMatch_s;
    logic rtMatch_s;

    // Loads into $0 never create a dependency.
    always_comb begin
        rsMatch_s = ID_UseRs & (ID_Rs == EX_WR_out);
        rtMatch_s = ID_UseRt & (ID_Rt == EX_WR_out);
        hz        = EX_MemRead & (EX_WR_out != {REG_AW{1'b0}}) & (rsMatch_s | rtMatch_s);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubble insertion and a saturating stall counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_AW  = REG_AW_DEF,
    parameter int ALUOP_W = ALUOP_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REG_AW-1:0]  ID_Rs,
    input  logic [REG_AW-1:0]  ID_Rt,
    input  logic [REG_AW-1:0]  ID_Rd,
    input  logic               ID_UseRs,
    input  logic               ID_UseRt,
    input  logic               ID_RegWrite,
    input  logic               ID_MemRead,
    input  logic               ID_MemWrite,
    input  logic               ID_MemtoReg,
    input  logic               ID_ALUSrc,
    input  logic               ID_RegDst,
    input  logic [ALUOP_W-1:0] ID_ALUOp,
    input  logic [DATA_W-1:0]  ID_RsData,
    input  logic [DATA_W-1:0]  ID_RtData,
    input  logic [DATA_W-1:0]  ID_Imm,
    input  logic [DATA_W-1:0]  ID_PC,
    input  logic               flush,
    output logic [REG_AW-1:0]  EX_Rs,
    output logic [REG_AW-1:0]  EX_Rt,
    output logic [REG_AW-1:0]  EX_Rd,
    output logic               EX_RegWrite,
    output logic               EX_MemRead,
    output logic               EX_MemWrite,
    output logic               EX_MemtoReg,
    output logic               EX_ALUSrc,
    output logic               EX_RegDst,
    output logic [ALUOP_W-1:0] EX_ALUOp,
    output logic [DATA_W-1:0]  EX_RsData,
    output logic [DATA_W-1:0]  EX_RtData,
    output logic [DATA_W-1:0]  EX_Imm,
    output logic [DATA_W-1:0]  EX_PC,
    output logic [REG_AW-1:0]  EX_WR_out,
    output logic               PCWrite,
    output logic               IFID_Write,
    output logic [CNT_W-1:0]   stall_cnt
);

    ctrl_t ctrl_r;
    ctrl_t idCtrl_s;
    logic  hazard_s;

    load_use_detect #(.REG_AW(REG_AW)) u_detect (
        .EX_MemRead (ctrl_r.memRead),
        .EX_WR_out  (EX_WR_out),
        .ID_Rs      (ID_Rs),
        .ID_Rt      (ID_Rt),
        .ID_UseRs   (ID_UseRs),
        .ID_UseRt   (ID_UseRt),
        .hz         (hazard_s)
    );

    // Pack ID control and derive stall enables; a flush lets the branch target load.
    always_comb begin
        idCtrl_s = '{regWrite: ID_RegWrite, memRead: ID_MemRead, memWrite: ID_MemWrite,
                     memtoReg: ID_MemtoReg, aluSrc: ID_ALUSrc, regDst: ID_RegDst};
        PCWrite    = ~hazard_s | flush;
        IFID_Write = ~hazard_s | flush;
    end

    assign EX_RegWrite = ctrl_r.regWrite;
    assign EX_MemRead  = ctrl_r.memRead;
    assign EX_MemWrite = ctrl_r.memWrite;
    assign EX_MemtoReg = ctrl_r.memtoReg;
    assign EX_ALUSrc   = ctrl_r.aluSrc;
    assign EX_RegDst   = ctrl_r.regDst;

    // Pipeline register: bubble on flush or hazard, otherwise capture ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush || hazard_s) begin
            ctrl_r    <= BUBBLE_CTRL;
            EX_Rs     <= {REG_AW{1'b0}};
            EX_Rt     <= {REG_AW{1'b0}};
            EX_Rd     <= {REG_AW{1'b0}};
            EX_WR_out <= {REG_AW{1'b0}};
            EX_ALUOp  <= {ALUOP_W{1'b0}};
            EX_RsData <= {DATA_W{1'b0}};
            EX_RtData <= {DATA_W{1'b0}};
            EX_Imm    <= {DATA_W{1'b0}};
            EX_PC     <= {DATA_W{1'b0}};
        end else begin
            ctrl_r    <= idCtrl_s;
            EX_Rs     <= ID_Rs;
            EX_Rt     <= ID_Rt;
            EX_Rd     <= ID_Rd;
            EX_WR_out <= ID_RegDst ? ID_Rd : ID_Rt;
            EX_ALUOp  <= ID_ALUOp;
            EX_RsData <= ID_RsData;
            EX_RtData <= ID_RtData;
            EX_Imm    <= ID_Imm;
            EX_PC     <= ID_PC;
        end
    end

    // Saturating count of load-use bubbles; flush-induced bubbles are not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= {CNT_W{1'b0}};
        end else if (hazard_s && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt <= stall_cnt;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver queues expected EX state, monitor compares after each edge.
module tb_id_ex_stage;

    localparam int VW = 157;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  ID_Rs = 5'd0, ID_Rt = 5'd0, ID_Rd = 5'd0;
    logic        ID_UseRs = 1'b0, ID_UseRt = 1'b0;
    logic        ID_RegWrite = 1'b0, ID_MemRead = 1'b0, ID_MemWrite = 1'b0;
    logic        ID_MemtoReg = 1'b0, ID_ALUSrc = 1'b0, ID_RegDst = 1'b0;
    logic [2:0]  ID_ALUOp = 3'd0;
    logic [31:0] ID_RsData = 32'd0, ID_RtData = 32'd0, ID_Imm = 32'd0, ID_PC = 32'd0;
    logic        flush = 1'b0;

    logic [4:0]  EX_Rs, EX_Rt, EX_Rd, EX_WR_out;
    logic        EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc, EX_RegDst;
    logic [2:0]  EX_ALUOp;
    logic [31:0] EX_RsData, EX_RtData, EX_Imm, EX_PC;
    logic        PCWrite, IFID_Write;
    logic [3:0]  stall_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int            id;
        logic [VW-1:0] vec;
        logic [3:0]    cnt;
    } exp_t;
    exp_t expQ[$];
    int   stepId = 0;

    id_ex_stage #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
        .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
        .ID_MemtoReg(ID_MemtoReg), .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst),
        .ID_ALUOp(ID_ALUOp), .ID_RsData(ID_RsData), .ID_RtData(ID_RtData),
        .ID_Imm(ID_Imm), .ID_PC(ID_PC), .flush(flush),
        .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
        .EX_MemtoReg(EX_MemtoReg), .EX_ALUSrc(EX_ALUSrc), .EX_RegDst(EX_RegDst),
        .EX_ALUOp(EX_ALUOp), .EX_RsData(EX_RsData), .EX_RtData(EX_RtData),
        .EX_Imm(EX_Imm), .EX_PC(EX_PC), .EX_WR_out(EX_WR_out),
        .PCWrite(PCWrite), .IFID_Write(IFID_Write), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] actVec();
        return {EX_Rs, EX_Rt, EX_Rd, EX_WR_out,
                EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc, EX_RegDst,
                EX_ALUOp, EX_RsData, EX_RtData, EX_Imm, EX_PC};
    endfunction

    // Expected EX contents: zero for a bubble, else the ID fields with the chosen destination.
    function automatic logic [VW-1:0] expVec(input logic bubble, input logic [4:0] wr);
        if (bubble) return '0;
        return {ID_Rs, ID_Rt, ID_Rd, wr,
                ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst,
                ID_ALUOp, ID_RsData, ID_RtData, ID_Imm, ID_PC};
    endfunction

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setId(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic useRs, input logic useRt, input logic memRead,
                         input logic regDst);
        ID_Rs = rs; ID_Rt = rt; ID_Rd = rd;
        ID_UseRs = useRs; ID_UseRt = useRt;
        ID_MemRead = memRead; ID_RegDst = regDst;
        ID_RegWrite = 1'b1; ID_MemtoReg = memRead; ID_ALUSrc = memRead;
        ID_MemWrite = 1'b0;
        ID_ALUOp = memRead ? 3'd0 : 3'd2;
        ID_RsData = 32'h1000_0000 + {27'd0, rs};
        ID_RtData = 32'h2000_0000 + {27'd0, rt};
        ID_Imm = {27'd0, rd} + 32'd4;
        ID_PC = ID_PC + 32'd4;
    endtask

    // One cycle: inputs already set at negedge; check stall outputs now, queue post-edge state.
    task automatic step(input logic expPcw, input logic expBubble, input logic [3:0] expCnt,
                        input logic [4:0] expWr);
        exp_t e;
        #1;
        check($sformatf("pcwrite[%0d]", stepId), {{(VW-2){1'b0}}, PCWrite, IFID_Write},
              {{(VW-2){1'b0}}, expPcw, expPcw});
        e.id = stepId; e.vec = expVec(expBubble, expWr); e.cnt = expCnt;
        expQ.push_back(e);
        stepId++;
        @(negedge clk);
    endtask

    // Monitor: compare the registered stage shortly after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check($sformatf("ex_regs[%0d]", e.id), actVec(), e.vec);
                check($sformatf("stall_cnt[%0d]", e.id), {{(VW-4){1'b0}}, stall_cnt},
                      {{(VW-4){1'b0}}, e.cnt});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] cnt;
        repeat (2) @(negedge clk);
        #1;
        check("reset_regs", actVec(), '0);
        check("reset_pcw", {{(VW-2){1'b0}}, PCWrite, IFID_Write}, {{(VW-2){1'b0}}, 2'b11});
        rst = 1'b0;
        @(negedge clk);

        // Pass-through with RegDst selecting Rd
        setId(5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        ID_Imm = 32'hFFFF_FFF0;
        step(1'b1, 1'b0, 4'd0, 5'd5);

        // lw $2 then dependent consumer: one bubble, then consumer latches
        setId(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 4'd0, 5'd2);
        setId(5'd2, 5'd6, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 4'd1, 5'd0);
        step(1'b1, 1'b0, 4'd1, 5'd8);

        // lw into $0 never stalls
        setId(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 4'd1, 5'd0);
        setId(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 4'd1, 5'd9);

        // lw $7 with consumer not using Rt
        setId(5'd1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 4'd1, 5'd7);
        setId(5'd3, 5'd7, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 4'd1, 5'd10);

        // Flush coincident with hazard: bubble, no stall, count unchanged
        setId(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 4'd1, 5'd2);
        setId(5'd2, 5'd6, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
        flush = 1'b1;
        step(1'b1, 1'b1, 4'd1, 5'd0);
        flush = 1'b0;
        step(1'b1, 1'b0, 4'd1, 5'd8);

        // Back-to-back loads, each consumer gets its own bubble
        setId(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 4'd1, 5'd2);
        setId(5'd2, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'd2, 5'd0);
        step(1'b1, 1'b0, 4'd2, 5'd3);
        setId(5'd5, 5'd3, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 4'd3, 5'd0);

        // Saturation at 4'hF over 20 load-use pairs
        cnt = 4'd3;
        for (int i = 0; i < 20; i++) begin
            setId(5'd1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
            step(1'b1, 1'b0, cnt, 5'd4);
            if (cnt != 4'hF) cnt = cnt + 4'd1;
            setId(5'd6, 5'd4, 5'd12, 1'b0, 1'b1, 1'b0, 1'b1);
            step(1'b0, 1'b1, cnt, 5'd0);
        end

        // Reset mid-stall: immediate clear without a clock edge
        setId(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 4'hF, 5'd2);
        setId(5'd2, 5'd6, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        check("midstall_pcw", {{(VW-2){1'b0}}, PCWrite, IFID_Write}, {{(VW-2){1'b0}}, 2'b00});
        rst = 1'b1;
        #1;
        check("async_reset_regs", actVec(), '0);
        check("async_reset_pcw", {{(VW-2){1'b0}}, PCWrite, IFID_Write}, {{(VW-2){1'b0}}, 2'b11});
        check("async_reset_cnt", {{(VW-4){1'b0}}, stall_cnt}, '0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 4'd0, 5'd8);

        repeat (2) @(negedge clk);
        check("queue_drained", VW'(expQ.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
